// File: rtl/str_lin_interp.sv
// AXI-stream linear interpolator: emits 2^LOG2R outputs per input, ramping from the previous sample to the current one.
// Define STR_LIN_INTERP_ZOH_EN to build a zero-order-hold variant (every output equals the previous sample).
module str_lin_interp #(
  parameter int DW    = 24,
  parameter int LOG2R = 2,
  parameter int LAST  = 16000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tlast,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready
);

  localparam int PW = DW + 1 + LOG2R;
  localparam int CW = (LAST > 1) ? $clog2(LAST) : 1;
  localparam logic [CW-1:0]    CNT_MAX = CW'(LAST - 1);
  localparam logic [LOG2R-1:0] K_MAX   = '1;

  localparam logic [1:0] PRIME = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] GEN   = 2'd2;

  logic [1:0]     state;
  logic [DW-1:0]  x0;
  logic [DW-1:0]  x1;
  logic [LOG2R-1:0] k;
  logic [CW-1:0]  pkt_cnt;
  logic [CW-1:0]  cnt_next;
  logic           slot_free;
  logic           out_hs;
  logic           gen_load;
  logic [DW-1:0]  y;

  assign slot_free = !m_axis_tvalid || m_axis_tready;
  assign out_hs    = m_axis_tvalid && m_axis_tready;
  assign gen_load  = (state == GEN) && slot_free;

  // Beat index of whatever gets loaded now: advances if the current beat is leaving this cycle.
  assign cnt_next = out_hs ? ((pkt_cnt == CNT_MAX) ? '0 : pkt_cnt + 1'b1) : pkt_cnt;

  assign s_axis_tready = !rst && ((state == PRIME) || (state == WAIT) ||
                                  ((state == GEN) && (k == K_MAX) && slot_free));

`ifdef STR_LIN_INTERP_ZOH_EN
  assign y = x0;
`else
  logic signed [DW:0]   d;
  logic signed [PW-1:0] p;

  assign d = {x1[DW-1], x1} - {x0[DW-1], x0};
  assign p = $signed({{LOG2R{d[DW]}}, d}) * $signed({{(DW+1){1'b0}}, k});
  // Arithmetic shift floors toward -inf; the sum never leaves [x0, x1] so truncation is exact.
  assign y = DW'($signed(x0) + (p >>> LOG2R));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= PRIME;
      x0            <= '0;
      x1            <= '0;
      k             <= '0;
      pkt_cnt       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (out_hs) begin
        pkt_cnt <= cnt_next;
      end
      if (out_hs && !gen_load) begin
        m_axis_tvalid <= 1'b0;
      end
      case (state)
        PRIME: begin
          if (s_axis_tvalid) begin
            x0    <= s_axis_tdata;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (s_axis_tvalid) begin
            x1    <= s_axis_tdata;
            k     <= '0;
            state <= GEN;
          end
        end
        GEN: begin
          if (slot_free) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= y;
            m_axis_tlast  <= (cnt_next == CNT_MAX);
            k             <= k + 1'b1;
            if (k == K_MAX) begin
              x0 <= x1;
              if (s_axis_tvalid) begin
                x1 <= s_axis_tdata;
              end else begin
                state <= WAIT;
              end
            end
          end
        end
        default: state <= PRIME;
      endcase
    end
  end

endmodule

// File: tb/tb_str_lin_interp.sv
// Randomised self-checking bench for str_lin_interp against a plain-arithmetic interpolation model.
// Runs with LAST=5 so packet framing is exercised within short streams.
module tb_str_lin_interp;

  localparam int DW    = 24;
  localparam int LOG2R = 2;
  localparam int R     = 1 << LOG2R;
  localparam int LAST  = 5;

  logic          clk;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;

  int checks = 0;
  int errors = 0;

  int            in_s[$];
  logic [DW-1:0] exp_d[$];
  logic          exp_l[$];
  logic [DW-1:0] out_d[$];
  logic          out_l[$];
  logic          out_r[$];
  int            out_c[$];
  int            hold_err = 0;
  int            cyc = 0;
  int            ready_mode = 0;

  str_lin_interp #(.DW(DW), .LOG2R(LOG2R), .LAST(LAST)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output ready pattern: 0 = always ready, 1 = toggle every cycle, 2 = random.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       m_axis_tready = !m_axis_tready;
        2:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b1;
      endcase
    end
  end

  // Collects delivered beats and counts any output that moves while stalled.
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_d;
    logic          prev_l;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_l = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_d || m_axis_tlast !== prev_l))
          hold_err++;
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
          out_d.push_back(m_axis_tdata);
          out_l.push_back(m_axis_tlast);
          out_r.push_back(s_axis_tready);
          out_c.push_back(cyc);
        end
        prev_stall = (m_axis_tvalid === 1'b1) && !m_axis_tready;
        prev_d = m_axis_tdata;
        prev_l = m_axis_tlast;
      end
    end
  end

  function automatic longint floor_div(input longint n);
    longint q;
    q = n / R;
    if ((n % R) != 0 && n < 0) q = q - 1;
    return q;
  endfunction

  // Reference: for each consecutive pair (a, b) emit a + floor((b-a)*k/R), k = 0..R-1; tlast on every LAST-th beat.
  task automatic build_expected();
    longint a, b, y;
    int beat;
    exp_d.delete();
    exp_l.delete();
    beat = 0;
    for (int i = 0; i + 1 < in_s.size(); i++) begin
      a = in_s[i];
      b = in_s[i+1];
      for (int kk = 0; kk < R; kk++) begin
`ifdef STR_LIN_INTERP_ZOH_EN
        y = a;
`else
        y = a + floor_div((b - a) * kk);
`endif
        beat++;
        exp_d.push_back(DW'(y));
        exp_l.push_back((beat % LAST) == 0);
      end
    end
  endtask

  task automatic clear_capture();
    out_d.delete();
    out_l.delete();
    out_r.delete();
    out_c.delete();
    hold_err = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_capture();
  endtask

  task automatic feed(input bit gaps, output bit ok);
    bit got;
    int waited;
    ok = 1'b1;
    for (int i = 0; i < in_s.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DW'(in_s[i]);
      waited = 0;
      do begin
        @(negedge clk);
        got = s_axis_tready;
        @(posedge clk);
        #1;
        waited++;
      end while (!got && waited < 200);
      if (!got) ok = 1'b0;
      s_axis_tvalid = 1'b0;
    end
  endtask

  task automatic wait_beats(input int n, output bit ok);
    int cnt;
    cnt = 0;
    while (out_d.size() < n && cnt < 500) begin
      @(posedge clk);
      cnt++;
    end
    ok = (out_d.size() >= n);
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tlast !== 1'b0 || s_axis_tready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values: got valid=%b data=%h last=%b s_ready=%b, want 0 0 0 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_capture();
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_reset: got s_ready=%b valid=%b, want 1 0", s_axis_tready, m_axis_tvalid);
    end
  endtask

  task automatic test_ramp();
    bit ok;
    int rdy;
    ready_mode = 0;
    do_reset();
    in_s = '{0, 100, 200};
    build_expected();
    feed(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL ramp_feed: input not accepted, want accepted"); end
    wait_beats(exp_d.size(), ok);
    checks++;
    if (out_d.size() != exp_d.size()) begin
      errors++;
      $display("[TB] FAIL ramp_count: got %0d beats, want %0d", out_d.size(), exp_d.size());
    end
    for (int j = 0; j < exp_d.size() && j < out_d.size(); j++) begin
      checks++;
      if (out_d[j] !== exp_d[j] || out_l[j] !== exp_l[j]) begin
        errors++;
        $display("[TB] FAIL ramp_beat%0d: got %0d/last=%b, want %0d/last=%b",
                 j, $signed(out_d[j]), out_l[j], $signed(exp_d[j]), exp_l[j]);
      end
    end
    if (out_c.size() >= 8) begin
      checks++;
      if (out_c[7] - out_c[0] != 7) begin
        errors++;
        $display("[TB] FAIL ramp_rate: got %0d cycles for 8 beats, want 7", out_c[7] - out_c[0]);
      end
      rdy = 0;
      for (int j = 0; j < 6; j++) rdy += int'(out_r[j]);
      checks++;
      if (rdy != 1) begin
        errors++;
        $display("[TB] FAIL ramp_s_ready: got %0d ready cycles over beats 0..5, want 1", rdy);
      end
    end
  endtask

  task automatic test_values(input string name, input int a, input int b);
    bit ok;
    ready_mode = 0;
    do_reset();
    in_s = '{a, b};
    build_expected();
    feed(1'b0, ok);
    wait_beats(exp_d.size(), ok);
    checks++;
    if (!ok || out_d.size() != exp_d.size()) begin
      errors++;
      $display("[TB] FAIL %s_count: got %0d beats, want %0d", name, out_d.size(), exp_d.size());
    end
    for (int j = 0; j < exp_d.size() && j < out_d.size(); j++) begin
      checks++;
      if (out_d[j] !== exp_d[j]) begin
        errors++;
        $display("[TB] FAIL %s_beat%0d: got %0d, want %0d", name, j, $signed(out_d[j]), $signed(exp_d[j]));
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    ready_mode = 1;
    do_reset();
    in_s = '{10, 50, -30};
    build_expected();
    feed(1'b0, ok);
    wait_beats(exp_d.size(), ok);
    checks++;
    if (!ok || out_d.size() != exp_d.size()) begin
      errors++;
      $display("[TB] FAIL bp_count: got %0d beats, want %0d", out_d.size(), exp_d.size());
    end
    for (int j = 0; j < exp_d.size() && j < out_d.size(); j++) begin
      checks++;
      if (out_d[j] !== exp_d[j] || out_l[j] !== exp_l[j]) begin
        errors++;
        $display("[TB] FAIL bp_beat%0d: got %0d/last=%b, want %0d/last=%b",
                 j, $signed(out_d[j]), out_l[j], $signed(exp_d[j]), exp_l[j]);
      end
    end
    checks++;
    if (hold_err != 0) begin
      errors++;
      $display("[TB] FAIL bp_hold: got %0d stalled-cycle changes, want 0", hold_err);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int cnt;
    ready_mode = 0;
    do_reset();
    in_s = '{40, 80};
    feed(1'b0, ok);
    cnt = 0;
    while (out_d.size() < 2 && cnt < 200) begin
      @(posedge clk);
      cnt++;
    end
    checks++;
    if (out_d.size() < 2) begin errors++; $display("[TB] FAIL mid_rst_prelude: got %0d beats, want 2", out_d.size()); end
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_rst_drop: got valid=%b s_ready=%b, want 0 1", m_axis_tvalid, s_axis_tready);
    end
    @(posedge clk);
    #1;
    clear_capture();
    in_s = '{7, 11, 15};
    build_expected();
    feed(1'b0, ok);
    wait_beats(exp_d.size(), ok);
    checks++;
    if (!ok || out_d.size() != exp_d.size()) begin
      errors++;
      $display("[TB] FAIL mid_rst_count: got %0d beats, want %0d", out_d.size(), exp_d.size());
    end
    for (int j = 0; j < exp_d.size() && j < out_d.size(); j++) begin
      checks++;
      if (out_d[j] !== exp_d[j] || out_l[j] !== exp_l[j]) begin
        errors++;
        $display("[TB] FAIL mid_rst_beat%0d: got %0d/last=%b, want %0d/last=%b",
                 j, $signed(out_d[j]), out_l[j], $signed(exp_d[j]), exp_l[j]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    ready_mode = 2;
    do_reset();
    in_s.delete();
    for (int i = 0; i < 6; i++) in_s.push_back(int'($urandom_range(0, 16777215)) - 8388608);
    build_expected();
    feed(1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL rand_feed: input not accepted, want accepted"); end
    wait_beats(exp_d.size(), ok);
    checks++;
    if (out_d.size() != exp_d.size()) begin
      errors++;
      $display("[TB] FAIL rand_count: got %0d beats, want %0d", out_d.size(), exp_d.size());
    end
    for (int j = 0; j < exp_d.size() && j < out_d.size(); j++) begin
      checks++;
      if (out_d[j] !== exp_d[j] || out_l[j] !== exp_l[j]) begin
        errors++;
        $display("[TB] FAIL rand_beat%0d: got %0d/last=%b, want %0d/last=%b",
                 j, $signed(out_d[j]), out_l[j], $signed(exp_d[j]), exp_l[j]);
      end
    end
    checks++;
    if (hold_err != 0) begin
      errors++;
      $display("[TB] FAIL rand_hold: got %0d stalled-cycle changes, want 0", hold_err);
    end
  endtask

  initial begin
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    test_reset();
    test_ramp();
    test_values("neg", 100, -1);
    test_values("full", -8388608, 8388607);
    test_backpressure();
    test_mid_reset();
    for (int n = 0; n < 3; n++) test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
